// File: rtl/raster_pixel_writer.sv
// raster_pixel_writer
//   Buffers the rasterizer pixel stream in a small FIFO and writes it into the
//   framebuffer through a request/acknowledge port. Also sweeps the whole
//   framebuffer to colour 0 when a clear is requested.
//
// Handshake: mem_req_o is a write offer; mem_addr_o/mem_data_o are held
//   constant while mem_req_o=1 until a cycle with mem_ack_i=1, at whose
//   closing edge the write is considered accepted. The pixel input has no
//   backpressure: a pixel that finds the FIFO full is dropped and counted.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   pix_valid_i     pixel present this cycle
//   pix_addr_i      linear pixel address (y*640+x)
//   pix_color_i     pixel colour
//   clear_req_i     one-cycle pulse requesting a framebuffer clear
//   mem_req_o       write request to the arbiter
//   mem_addr_o      write address (holds last value while idle)
//   mem_data_o      write data (holds last value while idle)
//   mem_ack_i       write accepted this cycle
//   clear_busy_o    clear pending or in progress
//   fifo_count_o    FIFO occupancy
//   overflow_o      sticky: at least one pixel dropped
//   drop_count_o    dropped pixels, saturating
//   idle_o          FSM idle, FIFO empty, no clear pending
//   state_o         FSM state (debug)
module raster_pixel_writer #(
    parameter int DEPTH    = 16,
    parameter int ADDR_W   = 19,
    parameter int COLOR_W  = 4,
    parameter int FB_WORDS = 307200,
    localparam int PTR_W   = $clog2(DEPTH),
    localparam int CNT_W   = PTR_W + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pix_valid_i,
    input  logic [ADDR_W-1:0]  pix_addr_i,
    input  logic [COLOR_W-1:0] pix_color_i,
    input  logic               clear_req_i,
    output logic               mem_req_o,
    output logic [ADDR_W-1:0]  mem_addr_o,
    output logic [COLOR_W-1:0] mem_data_o,
    input  logic               mem_ack_i,
    output logic               clear_busy_o,
    output logic [CNT_W-1:0]   fifo_count_o,
    output logic               overflow_o,
    output logic [15:0]        drop_count_o,
    output logic               idle_o,
    output logic [1:0]         state_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_CLEAR = 2'd2
    } state_t;

    localparam int WORD_W = ADDR_W + COLOR_W;

    state_t              state_q, state_d;
    logic [WORD_W-1:0]   fifo_mem_q [DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                clear_pend_q, clear_pend_d;
    logic [ADDR_W-1:0]   clear_cnt_q, clear_cnt_d;
    logic                overflow_q, overflow_d;
    logic [15:0]         drop_q, drop_d;
    logic [ADDR_W-1:0]   hold_addr_q;
    logic [COLOR_W-1:0]  hold_data_q;

    logic                full, push, drop, pop;
    logic                clear_accept, clear_last;
    logic [WORD_W-1:0]   head;

    assign full         = (count_q == CNT_W'(DEPTH));
    // Full is judged on the registered count, so a pop in the same cycle
    // cannot make room for an arriving pixel.
    assign push         = pix_valid_i && !full;
    assign drop         = pix_valid_i && full;
    assign pop          = (state_q == ST_DRAIN) && mem_ack_i;
    assign clear_accept = clear_req_i && !clear_pend_q;
    assign clear_last   = (clear_cnt_q == ADDR_W'(FB_WORDS - 1));
    assign head         = fifo_mem_q[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        if (push && !pop)      count_d = count_q + CNT_W'(1);
        else if (pop && !push) count_d = count_q - CNT_W'(1);
    end

    always_comb begin
        overflow_d = clear_accept ? 1'b0 : overflow_q;
        drop_d     = clear_accept ? 16'd0 : drop_q;
        if (drop) begin
            overflow_d = 1'b1;
            if (drop_d != 16'hFFFF) drop_d = drop_d + 16'd1;
        end
    end

    // FSM next state and memory-port outputs.
    always_comb begin
        state_d      = state_q;
        clear_cnt_d  = clear_cnt_q;
        clear_pend_d = clear_pend_q;
        mem_req_o    = 1'b0;
        mem_addr_o   = hold_addr_q;
        mem_data_o   = hold_data_q;
        if (clear_accept) clear_pend_d = 1'b1;
        unique case (state_q)
            ST_IDLE: begin
                if (clear_pend_q) begin
                    state_d     = ST_CLEAR;
                    clear_cnt_d = '0;
                end else if (count_q != '0) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                mem_req_o  = 1'b1;
                mem_addr_o = head[WORD_W-1:COLOR_W];
                mem_data_o = head[COLOR_W-1:0];
                // Yield to a pending clear only after the current write lands.
                if (mem_ack_i && (count_d == '0 || clear_pend_q)) state_d = ST_IDLE;
            end
            ST_CLEAR: begin
                mem_req_o  = 1'b1;
                mem_addr_o = clear_cnt_q;
                mem_data_o = '0;
                if (mem_ack_i) begin
                    if (clear_last) begin
                        state_d      = ST_IDLE;
                        clear_pend_d = 1'b0;
                    end else begin
                        clear_cnt_d = clear_cnt_q + ADDR_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            clear_pend_q <= 1'b0;
            clear_cnt_q  <= '0;
            overflow_q   <= 1'b0;
            drop_q       <= '0;
            hold_addr_q  <= '0;
            hold_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            clear_pend_q <= clear_pend_d;
            clear_cnt_q  <= clear_cnt_d;
            overflow_q   <= overflow_d;
            drop_q       <= drop_d;
            hold_addr_q  <= mem_addr_o;
            hold_data_q  <= mem_data_o;
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        end
    end

    // Storage needs no reset; occupancy is tracked by count_q.
    always_ff @(posedge clk) begin
        if (push) fifo_mem_q[wr_ptr_q] <= {pix_addr_i, pix_color_i};
    end

    assign clear_busy_o = clear_pend_q;
    assign fifo_count_o = count_q;
    assign overflow_o   = overflow_q;
    assign drop_count_o = drop_q;
    assign idle_o       = (state_q == ST_IDLE) && (count_q == '0) && !clear_pend_q;
    assign state_o      = state_q;

endmodule

// File: tb/tb_raster_pixel_writer.sv
module tb_raster_pixel_writer;

    logic        clk = 1'b0;
    logic        rst;
    logic        pix_valid_i;
    logic [18:0] pix_addr_i;
    logic [3:0]  pix_color_i;
    logic        clear_req_i;
    logic        mem_req_o;
    logic [18:0] mem_addr_o;
    logic [3:0]  mem_data_o;
    logic        mem_ack_i;
    logic        clear_busy_o;
    logic [4:0]  fifo_count_o;
    logic        overflow_o;
    logic [15:0] drop_count_o;
    logic        idle_o;
    logic [1:0]  state_o;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int stable_err = 0;

    logic [22:0] got_q[$];
    int          got_cyc_q[$];
    logic [22:0] exp_q[$];
    logic        prev_wait = 1'b0;
    logic [22:0] prev_word = '0;

    raster_pixel_writer #(
        .DEPTH(16), .ADDR_W(19), .COLOR_W(4), .FB_WORDS(8)
    ) dut (
        .clk(clk), .rst(rst),
        .pix_valid_i(pix_valid_i), .pix_addr_i(pix_addr_i), .pix_color_i(pix_color_i),
        .clear_req_i(clear_req_i),
        .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
        .mem_ack_i(mem_ack_i),
        .clear_busy_o(clear_busy_o), .fifo_count_o(fifo_count_o),
        .overflow_o(overflow_o), .drop_count_o(drop_count_o),
        .idle_o(idle_o), .state_o(state_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Write monitor: records accepted writes and flags any change of the
    // offered address/data while a request is waiting for its ack.
    always @(negedge clk) begin
        if (mem_req_o && mem_ack_i) begin
            got_q.push_back({mem_addr_o, mem_data_o});
            got_cyc_q.push_back(cyc);
        end
        if (prev_wait && mem_req_o && ({mem_addr_o, mem_data_o} !== prev_word))
            stable_err++;
        prev_wait = mem_req_o && !mem_ack_i;
        prev_word = {mem_addr_o, mem_data_o};
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        got_q.delete();
        got_cyc_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1; pix_valid_i = 1'b0; pix_addr_i = '0; pix_color_i = '0;
        clear_req_i = 1'b0; mem_ack_i = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        checks++;
        if ({mem_req_o, mem_addr_o, mem_data_o} !== 24'd0) begin
            failures++;
            $display("FAIL reset_mem got req=%0b addr=%0d data=%0h want 0/0/0", mem_req_o, mem_addr_o, mem_data_o);
        end
        checks++;
        if ({clear_busy_o, fifo_count_o, overflow_o, drop_count_o} !== 23'd0) begin
            failures++;
            $display("FAIL reset_status got busy=%0b cnt=%0d ovf=%0b drop=%0d want all 0", clear_busy_o, fifo_count_o, overflow_o, drop_count_o);
        end
        checks++;
        if (idle_o !== 1'b1) begin
            failures++;
            $display("FAIL reset_idle got %0b want 1", idle_o);
        end
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single();
        clear_logs();
        mem_ack_i = 1'b1;
        pix_valid_i = 1'b1; pix_addr_i = 19'd1000; pix_color_i = 4'hA;
        tick();
        pix_valid_i = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_req_o !== 1'b0 || fifo_count_o !== 5'd1) begin
            failures++;
            $display("FAIL single_push_cycle got req=%0b cnt=%0d want req=0 cnt=1", mem_req_o, fifo_count_o);
        end
        tick();
        @(negedge clk);
        checks++;
        if (mem_req_o !== 1'b1 || mem_addr_o !== 19'd1000 || mem_data_o !== 4'hA) begin
            failures++;
            $display("FAIL single_write got req=%0b addr=%0d data=%0h want 1/1000/a", mem_req_o, mem_addr_o, mem_data_o);
        end
        tick();
        @(negedge clk);
        checks++;
        if (mem_req_o !== 1'b0 || idle_o !== 1'b1 || mem_addr_o !== 19'd1000 || mem_data_o !== 4'hA) begin
            failures++;
            $display("FAIL single_after got req=%0b idle=%0b addr=%0d data=%0h want 0/1/1000/a", mem_req_o, idle_o, mem_addr_o, mem_data_o);
        end
        repeat (3) tick();
        checks++;
        if (got_q.size() != 1 || got_q[0] !== {19'd1000, 4'hA}) begin
            failures++;
            $display("FAIL single_log got size=%0d want 1 write of 1000/a", got_q.size());
        end
    endtask

    task automatic test_burst16();
        clear_logs();
        mem_ack_i = 1'b0;
        for (int i = 0; i < 16; i++) begin
            pix_valid_i = 1'b1; pix_addr_i = 19'(100 + i); pix_color_i = 4'(i);
            tick();
        end
        pix_valid_i = 1'b0;
        repeat (4) tick();
        @(negedge clk);
        checks++;
        if (fifo_count_o !== 5'd16 || overflow_o !== 1'b0 || drop_count_o !== 16'd0) begin
            failures++;
            $display("FAIL burst16_full got cnt=%0d ovf=%0b drop=%0d want 16/0/0", fifo_count_o, overflow_o, drop_count_o);
        end
        checks++;
        if (mem_req_o !== 1'b1 || mem_addr_o !== 19'd100 || mem_data_o !== 4'h0) begin
            failures++;
            $display("FAIL burst16_head got req=%0b addr=%0d data=%0h want 1/100/0", mem_req_o, mem_addr_o, mem_data_o);
        end
        tick();
        mem_ack_i = 1'b1;
        repeat (20) tick();
        checks++;
        if (got_q.size() != 16) begin
            failures++;
            $display("FAIL burst16_count got %0d want 16", got_q.size());
        end else begin
            for (int i = 0; i < 16; i++) begin
                checks++;
                if (got_q[i] !== {19'(100 + i), 4'(i)} || got_cyc_q[i] != got_cyc_q[0] + i) begin
                    failures++;
                    $display("FAIL burst16_write%0d got %h at +%0d want %h at +%0d", i, got_q[i], got_cyc_q[i] - got_cyc_q[0], {19'(100 + i), 4'(i)}, i);
                end
            end
        end
    endtask

    task automatic test_overflow();
        clear_logs();
        mem_ack_i = 1'b0;
        for (int i = 0; i < 20; i++) begin
            pix_valid_i = 1'b1; pix_addr_i = 19'(200 + i); pix_color_i = 4'(i + 3);
            tick();
        end
        pix_valid_i = 1'b0;
        @(negedge clk);
        checks++;
        if (fifo_count_o !== 5'd16 || overflow_o !== 1'b1 || drop_count_o !== 16'd4) begin
            failures++;
            $display("FAIL overflow_status got cnt=%0d ovf=%0b drop=%0d want 16/1/4", fifo_count_o, overflow_o, drop_count_o);
        end
        tick();
        mem_ack_i = 1'b1;
        repeat (20) tick();
        checks++;
        if (got_q.size() != 16) begin
            failures++;
            $display("FAIL overflow_count got %0d want 16", got_q.size());
        end else begin
            for (int i = 0; i < 16; i++) begin
                checks++;
                if (got_q[i] !== {19'(200 + i), 4'(i + 3)}) begin
                    failures++;
                    $display("FAIL overflow_write%0d got %h want %h", i, got_q[i], {19'(200 + i), 4'(i + 3)});
                end
            end
        end
    endtask

    task automatic test_clear();
        int busy_cycles;
        busy_cycles = 0;
        clear_logs();
        mem_ack_i = 1'b1;
        for (int c = 0; c < 30; c++) begin
            // Second pulse at c=4 lands while busy and must be ignored.
            clear_req_i = (c == 0) || (c == 4);
            pix_valid_i = (c >= 3) && (c <= 5);
            pix_addr_i  = 19'(500 + c - 3);
            pix_color_i = 4'(c + 2);
            @(negedge clk);
            if (clear_busy_o) busy_cycles++;
            tick();
        end
        clear_req_i = 1'b0; pix_valid_i = 1'b0;
        for (int i = 0; i < 8; i++) exp_q.push_back({19'(i), 4'h0});
        for (int i = 0; i < 3; i++) exp_q.push_back({19'(500 + i), 4'(i + 5)});
        checks++;
        if (busy_cycles != 9) begin
            failures++;
            $display("FAIL clear_busy_len got %0d want 9", busy_cycles);
        end
        checks++;
        if (overflow_o !== 1'b0 || drop_count_o !== 16'd0) begin
            failures++;
            $display("FAIL clear_resets_drop got ovf=%0b drop=%0d want 0/0", overflow_o, drop_count_o);
        end
        checks++;
        if (got_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL clear_count got %0d want %0d", got_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin
                    failures++;
                    $display("FAIL clear_write%0d got %h want %h", i, got_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_random();
        clear_logs();
        stable_err = 0;
        for (int c = 0; c < 300; c++) begin
            mem_ack_i   = 1'($urandom_range(0, 1));
            pix_valid_i = ($urandom_range(0, 3) == 0);
            pix_addr_i  = 19'($urandom_range(0, 307199));
            pix_color_i = 4'($urandom_range(0, 15));
            if (pix_valid_i) exp_q.push_back({pix_addr_i, pix_color_i});
            tick();
        end
        pix_valid_i = 1'b0;
        mem_ack_i = 1'b1;
        repeat (40) tick();
        checks++;
        if (drop_count_o !== 16'd0) begin
            failures++;
            $display("FAIL random_drops got %0d want 0", drop_count_o);
        end
        checks++;
        if (stable_err != 0) begin
            failures++;
            $display("FAIL random_stable got %0d changes while waiting want 0", stable_err);
        end
        checks++;
        if (got_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL random_count got %0d want %0d", got_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin
                    failures++;
                    $display("FAIL random_write%0d got %h want %h", i, got_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        clear_logs();
        mem_ack_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            pix_valid_i = 1'b1; pix_addr_i = 19'(700 + i); pix_color_i = 4'hC;
            tick();
        end
        pix_valid_i = 1'b0;
        repeat (2) tick();
        @(negedge clk);
        checks++;
        if (fifo_count_o !== 5'd5 || mem_req_o !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_pre got cnt=%0d req=%0b want 5/1", fifo_count_o, mem_req_o);
        end
        tick();
        got_q.delete();
        rst = 1'b1;
        tick();
        @(negedge clk);
        checks++;
        if (mem_req_o !== 1'b0 || fifo_count_o !== 5'd0 || mem_addr_o !== 19'd0 || idle_o !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_post got req=%0b cnt=%0d addr=%0d idle=%0b want 0/0/0/1", mem_req_o, fifo_count_o, mem_addr_o, idle_o);
        end
        tick();
        rst = 1'b0;
        mem_ack_i = 1'b1;
        repeat (10) tick();
        checks++;
        if (got_q.size() != 0) begin
            failures++;
            $display("FAIL rstmid_writes got %0d want 0", got_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst16();
        test_overflow();
        test_clear();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
